load_store_unit: RTL
====================

Name: load_store_unit

Overview:
- Sits between the execute stage and data port B of the dual-port data RAM.
- Accepts one load/store request at a time, aligned to byte/half/word size.
- Generates the word address, byte write-enables and lane-replicated write data.
- Waits for the RAM's one-cycle read latency, then returns the selected lane sign- or zero-extended, with misalignment checking.

Parameters:
- MEM_DISABLE, 2'b00: mem_op encoding, no access.
- MEM_READ_SEXT, 2'b01: mem_op encoding, load with sign extension.
- MEM_READ_ZEXT, 2'b10: mem_op encoding, load with zero extension.
- MEM_WRITE, 2'b11: mem_op encoding, store.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  unit can accept a request this cycle
- mem_op  in  2  operation, encoded per parameters
- size  in  2  00 byte, 01 half, 10 word, 11 illegal
- addr  in  32  byte address
- wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle pulse, request complete
- resp_data  out  32  extended load data; 0 for stores and faults
- misaligned  out  1  valid with resp_valid; access faulted, no RAM access made
- ram_addr  out  32  byte address to RAM, always {addr[31:2],2'b00}
- ram_din  out  32  lane-replicated store data
- ram_en  out  1  RAM port enable
- ram_we  out  4  byte write enables
- ram_dout  in  32  RAM read data
- ram_read_valid  in  1  RAM read data valid (cycle after a read enable)
- ram_not_ready  in  1  RAM busy; no request may be accepted

Behaviour:
- Reset values:
  - state IDLE.
  - req_ready 0 during reset, 1 in IDLE otherwise.
  - resp_valid 0, resp_data 0, misaligned 0.
  - ram_en 0, ram_we 0, ram_din 0, ram_addr 0.
- Accept condition: state==IDLE & req_valid & !ram_not_ready & mem_op!=MEM_DISABLE.
- req_ready = (state==IDLE) & !ram_not_ready.
- mem_op==MEM_DISABLE with req_valid: ignored; no response.
- RAM outputs are combinational from the request in the accept cycle only; ram_en=0 and ram_we=0 in all other cycles.
- Misaligned rule:
  - size 01 with addr[0]=1 faults.
  - size 10 with addr[1:0]!=0 faults.
  - size 11 always faults.
- Faulted request:
  - No ram_en.
  - Next cycle: resp_valid=1, misaligned=1, resp_data=0.
  - Returns to IDLE.
- Store (state IDLE -> RESP):
  - ram_en=1.
  - Byte: ram_we=4'b0001<<addr[1:0], ram_din={4{wdata[7:0]}}.
  - Half: ram_we=4'b0011<<{addr[1],1'b0}, ram_din={2{wdata[15:0]}}.
  - Word: ram_we=4'b1111, ram_din=wdata.
  - Next cycle: resp_valid=1, resp_data=0. Store latency 1.
- Load (IDLE -> WAIT -> RESP):
  - Accept cycle: ram_en=1, ram_we=0.
  - Latch addr[1:0], size and sext (mem_op==MEM_READ_SEXT) into registers.
  - WAIT: hold until ram_read_valid=1 (no timeout).
  - Extraction: lane = ram_dout >> (offset*8). Byte takes lane[7:0], half takes lane[15:0], word takes all 32 bits. Sign- or zero-extend per latched sext.
  - Result is registered; resp_valid pulses the cycle after ram_read_valid. Nominal load latency 2.
- RESP state: lasts exactly one cycle. req_ready=0, then back to IDLE. Back-to-back throughput: one store per 2 cycles, one load per 3 cycles.
- ram_not_ready high in IDLE: no accept; the request is held by upstream.
- ram_not_ready during WAIT: ignored.
- ram_read_valid while not in WAIT: ignored.
- Reset mid-operation: drops the in-flight request, no response, IDLE the next cycle.

Test Plan:
- Reset, then word store addr=0x100, wdata=0xDEADBEEF -> accept cycle ram_en=1, ram_we=4'b1111, ram_addr=0x100, ram_din=0xDEADBEEF; next cycle resp_valid=1, misaligned=0.
- Byte store addr=0x103, wdata=0x000000A5 -> ram_we=4'b1000, ram_din=0xA5A5A5A5, ram_addr=0x100.
- Model ram_dout=0xDEADBEEF: SEXT byte load addr=0x101 -> resp_data=0xFFFFFFBE; ZEXT -> 0x000000BE; SEXT half addr=0x102 -> 0xFFFFDEAD; word -> 0xDEADBEEF. Each has resp_valid 2 cycles after accept.
- Half load addr=0x101, word store addr=0x102, size=11 -> ram_en never high; resp_valid+misaligned=1 next cycle with resp_data=0.
- ram_not_ready=1 for 3 cycles with req_valid held -> req_ready=0, no ram_en; accept in the first cycle after it drops.
- Load accepted, reset asserted in WAIT -> no resp_valid; req_ready=1 the cycle after reset deasserts; a following request completes normally.

Source files
------------

// File: rtl/load_store_unit_if.sv
// Request/response bus between the execute stage and the load/store unit.
// Handshake: a request transfers on a clock edge where req_valid && req_ready
// and mem_op != MEM_DISABLE; upstream holds the request stable until then.
// resp_valid is a one-cycle pulse with no backpressure; misaligned and
// resp_data are meaningful only while resp_valid is high.
interface load_store_unit_if;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  mem_op;
    logic [1:0]  size;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        resp_valid;
    logic [31:0] resp_data;
    logic        misaligned;

    modport master (
        output req_valid, mem_op, size, addr, wdata,
        input  req_ready, resp_valid, resp_data, misaligned
    );

    modport slave (
        input  req_valid, mem_op, size, addr, wdata,
        output req_ready, resp_valid, resp_data, misaligned
    );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit driving port B of the data RAM. One request in flight:
// stores complete the cycle after accept, loads wait for the RAM's read
// data, extract and extend the addressed lane, then respond.
module load_store_unit #(
    parameter logic [1:0] MEM_DISABLE   = 2'b00,
    parameter logic [1:0] MEM_READ_SEXT = 2'b01,
    parameter logic [1:0] MEM_READ_ZEXT = 2'b10,
    parameter logic [1:0] MEM_WRITE     = 2'b11
) (
    input  logic                    clk,
    input  logic                    reset,
    load_store_unit_if.slave        bus,
    output logic [31:0]             ram_addr,
    output logic [31:0]             ram_din,
    output logic                    ram_en,
    output logic [3:0]              ram_we,
    input  logic [31:0]             ram_dout,
    input  logic                    ram_read_valid,
    input  logic                    ram_not_ready,
    output logic [1:0]              debugState
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        WAIT = 2'b01,
        RESP = 2'b10
    } stateType;

    stateType    state;
    stateType    nextState;
    logic        accept;
    logic        fault;
    logic [1:0]  offsetQ;
    logic [1:0]  sizeQ;
    logic        sextQ;
    logic [31:0] respDataQ;
    logic        misalignedQ;
    logic [31:0] lane;
    logic [31:0] loadResult;

    // Ready only when idle, the RAM is free and we are not in reset.
    assign bus.req_ready  = (state == IDLE) && !ram_not_ready && !reset;
    assign accept         = bus.req_ready && bus.req_valid && (bus.mem_op != MEM_DISABLE);
    assign bus.resp_valid = (state == RESP);
    assign bus.resp_data  = respDataQ;
    assign bus.misaligned = misalignedQ && (state == RESP);
    assign debugState     = state;

    // Alignment check on the incoming request.
    always_comb begin
        fault = 1'b0;
        case (bus.size)
            2'b00:   fault = 1'b0;
            2'b01:   fault = bus.addr[0];
            2'b10:   fault = (bus.addr[1:0] != 2'b00);
            default: fault = 1'b1;
        endcase
    end

    // Next-state logic; RAM strobes are driven only in the accept cycle.
    always_comb begin
        nextState = state;
        ram_en    = 1'b0;
        ram_we    = 4'b0000;
        ram_addr  = 32'h0;
        ram_din   = 32'h0;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (fault) begin
                        nextState = RESP;
                    end else begin
                        ram_en   = 1'b1;
                        ram_addr = {bus.addr[31:2], 2'b00};
                        if (bus.mem_op == MEM_WRITE) begin
                            nextState = RESP;
                            case (bus.size)
                                2'b00: begin
                                    ram_we  = 4'b0001 << bus.addr[1:0];
                                    ram_din = {4{bus.wdata[7:0]}};
                                end
                                2'b01: begin
                                    ram_we  = 4'b0011 << {bus.addr[1], 1'b0};
                                    ram_din = {2{bus.wdata[15:0]}};
                                end
                                default: begin
                                    ram_we  = 4'b1111;
                                    ram_din = bus.wdata;
                                end
                            endcase
                        end else begin
                            nextState = WAIT;
                        end
                    end
                end
            end
            WAIT: begin
                if (ram_read_valid) begin
                    nextState = RESP;
                end
            end
            RESP: begin
                nextState = IDLE;
            end
            default: begin
                nextState = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Shift the addressed lane down and extend it per the latched load kind.
    always_comb begin
        lane       = ram_dout >> {offsetQ, 3'b000};
        loadResult = lane;
        case (sizeQ)
            2'b00:   loadResult = sextQ ? {{24{lane[7]}}, lane[7:0]} : {24'h0, lane[7:0]};
            2'b01:   loadResult = sextQ ? {{16{lane[15]}}, lane[15:0]} : {16'h0, lane[15:0]};
            default: loadResult = lane;
        endcase
    end

    // Latch request attributes on accept; capture load data when it arrives.
    always_ff @(posedge clk) begin
        if (reset) begin
            offsetQ     <= 2'b00;
            sizeQ       <= 2'b00;
            sextQ       <= 1'b0;
            respDataQ   <= 32'h0;
            misalignedQ <= 1'b0;
        end else if (accept) begin
            offsetQ     <= bus.addr[1:0];
            sizeQ       <= bus.size;
            sextQ       <= (bus.mem_op == MEM_READ_SEXT);
            respDataQ   <= 32'h0;
            misalignedQ <= fault;
        end else if ((state == WAIT) && ram_read_valid) begin
            respDataQ   <= loadResult;
        end
    end

endmodule
